// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider (q = a / b), one quotient bit per cycle, RNE, denormals.
// Define FP_DIV_FTZ_EN for flush-to-zero of denormal inputs and underflowing results.
module fp_divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;

    typedef struct packed {
        logic [23:0]       mant;
        logic signed [9:0] exp;
    } unp_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt;

    logic [31:0]       a_p0, b_p0;
    logic              sign_p1, spec_p1, dbz_p1;
    logic [31:0]       spec_q_p1;
    logic [23:0]       mb_p1;
    logic signed [9:0] ea_p1, eb_p1;
    logic [25:0]       rem_p2, quo_p2;

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (m[i]) n = 5'(23 - i);
        return n;
    endfunction

    // Denormals use exponent -126 without hidden bit, then get left-justified.
    function automatic unp_t unpack_op(input logic [31:0] x);
        unp_t              r;
        logic [23:0]       m;
        logic [4:0]        lz;
        logic signed [9:0] e;
        if (x[30:23] == 8'h00) begin
            m = {1'b0, x[22:0]};
            e = -10'sd126;
        end else begin
            m = {1'b1, x[22:0]};
            e = $signed({2'b00, x[30:23]}) - 10'sd127;
        end
        lz     = lzc24(m);
        r.mant = m << lz;
        r.exp  = e - $signed({5'd0, lz});
        return r;
    endfunction

    function automatic logic [31:0] round_pack(input logic sign, input logic [25:0] quo,
                                               input logic rem_nz, input logic signed [9:0] ea,
                                               input logic signed [9:0] eb);
        logic signed [11:0] e;
        logic [23:0]        m;
        logic               g, s, inc;
        logic [11:0]        sh;
        logic [51:0]        wide;
        logic [7:0]         ef;
        logic [31:0]        res;
        e = 12'(ea) - 12'(eb) + 12'sd127;
        if (quo[25]) begin
            m = quo[25:2];
            g = quo[1];
            s = quo[0] | rem_nz;
        end else begin
            m = quo[24:1];
            g = quo[0];
            s = rem_nz;
            e = e - 12'sd1;
        end
        ef = e[7:0];
        // Gradual underflow: denormalize before rounding so RNE sees the true guard/sticky.
        if (e <= 12'sd0) begin
            sh = 12'sd1 - e;
            if (sh > 12'd26) sh = 12'd26;
            wide = {m, g, 27'h0} >> sh;
            m    = wide[51:28];
            g    = wide[27];
            s    = s | (|wide[26:0]);
            ef   = 8'h00;
        end
        inc = g & (s | m[0]);
        res = {sign, {ef, m[22:0]} + {30'h0, inc}};
        if (e >= 12'sd255)
            res = {sign, 8'hff, 23'h0};
`ifdef FP_DIV_FTZ_EN
        else if (e <= 12'sd0)
            res = {sign, 31'h0};
`endif
        return res;
    endfunction

    logic  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign_u;
    logic  spec_u, dbz_u;
    logic [31:0] spec_q_u;
    unp_t  ua, ub;

    always_comb begin
        nan_a  = (a_p0[30:23] == 8'hff) && (a_p0[22:0] != 23'h0);
        nan_b  = (b_p0[30:23] == 8'hff) && (b_p0[22:0] != 23'h0);
        inf_a  = (a_p0[30:23] == 8'hff) && (a_p0[22:0] == 23'h0);
        inf_b  = (b_p0[30:23] == 8'hff) && (b_p0[22:0] == 23'h0);
`ifdef FP_DIV_FTZ_EN
        zero_a = (a_p0[30:23] == 8'h00);
        zero_b = (b_p0[30:23] == 8'h00);
`else
        zero_a = (a_p0[30:0] == 31'h0);
        zero_b = (b_p0[30:0] == 31'h0);
`endif
        sign_u   = a_p0[31] ^ b_p0[31];
        ua       = unpack_op(a_p0);
        ub       = unpack_op(b_p0);
        spec_u   = 1'b1;
        dbz_u    = 1'b0;
        spec_q_u = 32'h0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_q_u = 32'h7fc00000;
        end else if (inf_a || zero_b) begin
            spec_q_u = {sign_u, 8'hff, 23'h0};
            dbz_u    = zero_b && !inf_a;
        end else if (zero_a || inf_b) begin
            spec_q_u = {sign_u, 31'h0};
        end else begin
            spec_u   = 1'b0;
        end
    end

    logic        q_bit;
    logic [25:0] rem_sub;

    always_comb begin
        q_bit   = rem_p2 >= {2'b00, mb_p1};
        rem_sub = q_bit ? (rem_p2 - {2'b00, mb_p1}) : rem_p2;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = DIVIDE;
            DIVIDE:  if (cnt == 5'd25) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            if (state == UNPACK)
                cnt <= 5'd0;
            else if (state == DIVIDE)
                cnt <= cnt + 5'd1;
        end
    end

    // Operand capture -> unpack (_p1) -> restoring divide (_p2)
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_p0 <= a;
            b_p0 <= b;
        end
        if (state == UNPACK) begin
            sign_p1   <= sign_u;
            spec_p1   <= spec_u;
            spec_q_p1 <= spec_q_u;
            dbz_p1    <= dbz_u;
            ea_p1     <= ua.exp;
            eb_p1     <= ub.exp;
            mb_p1     <= ub.mant;
            rem_p2    <= {2'b00, ua.mant};
            quo_p2    <= 26'h0;
        end
        if (state == DIVIDE) begin
            rem_p2 <= {rem_sub[24:0], 1'b0};
            quo_p2 <= {quo_p2[24:0], q_bit};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= 32'h0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start)
                busy <= 1'b1;
            if (state == ROUND) begin
                busy        <= 1'b0;
                done        <= 1'b1;
                q           <= spec_p1 ? spec_q_p1
                                       : round_pack(sign_p1, quo_p2, |rem_p2, ea_p1, eb_p1);
                div_by_zero <= spec_p1 & dbz_p1;
            end
        end
    end

endmodule
